// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared state type, ROM content table and default parameters
//
// Contents:
//   DATA_W_DEF, DEPTH_DEF, ADDR_W_DEF, LEN_W_DEF : default parameter values
//   state_t                                      : reader FSM states
//   ROM_INIT / rom_word()                        : constant ROM contents
package rom_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 12;
    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned ROM_INIT_WORDS = 12;

    localparam logic [7:0] ROM_INIT [ROM_INIT_WORDS] = '{
        8'd90, 8'd80, 8'd40, 8'd60, 8'd50, 8'd40,
        8'd30, 8'd20, 8'd10, 8'd100, 8'd101, 8'd102
    };

    // Any address past the end of the initialised table reads as zero.
    function automatic logic [7:0] rom_word(input int unsigned idx);
        if (idx < ROM_INIT_WORDS) begin
            return ROM_INIT[idx[3:0]];
        end
        return 8'd0;
    endfunction

endpackage

// File: rtl/rom_sync.sv
// rtl/rom_sync.sv - constant ROM with registered read and read enable
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears q)
//   rd_en      : load q from rom[addr] on this edge
//   addr       : read address
//   q          : registered read data, holds while rd_en is low
module rom_sync
    import rom_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);

    // Sized to the full address space so every addr value indexes a real
    // entry; words at or beyond DEPTH are tied to zero.
    localparam int NUM = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NUM];

    for (genvar i = 0; i < NUM; i++) begin : g_rom
        assign mem[i] = (i < DEPTH) ? DATA_W'(rom_word(i)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (rd_en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst reader streaming consecutive ROM words
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : burst request handshake (ready only when idle)
//   req_dir               : burst start address
//   req_len               : burst length minus one
//   dato_valid/dato_ready : output word handshake
//   dato_s                : output word
//   dato_last             : marks the final word of a burst
//   err                   : one-cycle pulse after an out-of-range request
//   busy                  : high whenever a burst is in progress
module rom_burst_reader
    import rom_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_dir,
    input  logic [LEN_W-1:0]  req_len,
    output logic              dato_valid,
    input  logic              dato_ready,
    output logic [DATA_W-1:0] dato_s,
    output logic              dato_last,
    output logic              err,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    // Words still to be loaded after the one currently being loaded.
    logic [LEN_W-1:0]  remaining;

    logic              in_range;
    logic              accept_ok;
    logic              load_read;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADR) ? '0 : a + 1'b1;
    endfunction

    assign in_range  = ({1'b0, req_dir} < DEPTH_X);
    assign accept_ok = (state == IDLE) && req_valid && in_range;
    // The output register is free when it is empty or being consumed now.
    assign load_read = (state == READ) && (!dato_valid || dato_ready);

    // The first word is fetched on the accept edge itself, straight from
    // req_dir, which is what gives a single cycle of request-to-data latency.
    assign rd_en   = accept_ok || load_read;
    assign rd_addr = (state == IDLE) ? req_dir : addr;

    rom_sync #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_rom (
        .clk  (clk),
        .rst_n(rst_n),
        .rd_en(rd_en),
        .addr (rd_addr),
        .q    (dato_s)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            dato_valid <= 1'b0;
            dato_last  <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (in_range) begin
                            dato_valid <= 1'b1;
                            addr       <= next_addr(req_dir);
                            if (req_len == '0) begin
                                dato_last <= 1'b1;
                                remaining <= '0;
                                state     <= DRAIN;
                            end else begin
                                dato_last <= 1'b0;
                                remaining <= req_len - 1'b1;
                                state     <= READ;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (load_read) begin
                        dato_valid <= 1'b1;
                        addr       <= next_addr(addr);
                        if (remaining == '0) begin
                            dato_last <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dato_ready) begin
                        dato_valid <= 1'b0;
                        dato_last  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb/tb_rom_burst_reader.sv - self-checking bench for rom_burst_reader
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_dir;
    logic [3:0] req_len;
    logic       dato_valid;
    logic       dato_ready;
    logic [7:0] dato_s;
    logic       dato_last;
    logic       err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rom_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dir   (req_dir),
        .req_len   (req_len),
        .dato_valid(dato_valid),
        .dato_ready(dato_ready),
        .dato_s    (dato_s),
        .dato_last (dato_last),
        .err       (err),
        .busy      (busy)
    );

    localparam int TB_DEPTH = 12;

    function automatic logic [7:0] ref_word(input int idx);
        logic [7:0] tbl [12];
        tbl = '{90, 80, 40, 60, 50, 40, 30, 20, 10, 100, 101, 102};
        if (idx >= 0 && idx < 12) return tbl[idx];
        return 8'd0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_dir = '0; req_len = '0; dato_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dato_valid, dato_s, dato_last, err, busy} !== 12'h0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b s=%0d l=%b e=%b b=%b expected all 0",
                     dato_valid, dato_s, dato_last, err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: got req_ready=%b busy=%b expected 1/0", req_ready, busy);
        end
    endtask

    // Issue one in-range request and scoreboard the returned words against the
    // reference, with dato_ready drawn randomly at ready_pct percent.
    task automatic run_burst(input int dir, input int len, input int ready_pct, input string name);
        logic [7:0] exp_q [$];
        logic       prev_stall;
        logic [7:0] prev_s;
        logic       prev_l;
        int         cyc;
        for (int k = 0; k <= len; k++) exp_q.push_back(ref_word((dir + k) % TB_DEPTH));
        @(negedge clk);
        req_valid = 1'b1; req_dir = 8'(dir); req_len = 4'(len);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_req_ready: got %b expected 1", name, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (dato_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency: got valid=%b busy=%b expected 1/1", name, dato_valid, busy);
        end
        prev_stall = 1'b0; prev_s = '0; prev_l = 1'b0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            if (prev_stall) begin
                checks++;
                if (dato_valid !== 1'b1 || dato_s !== prev_s || dato_last !== prev_l) begin
                    failures++;
                    $display("FAIL %s_hold: got v=%b s=%0d l=%b expected 1 %0d %b",
                             name, dato_valid, dato_s, dato_last, prev_s, prev_l);
                end
            end
            dato_ready = ($urandom_range(99) < ready_pct);
            if (dato_valid && dato_ready) begin
                checks++;
                if (dato_s !== exp_q[0] || dato_last !== (exp_q.size() == 1)) begin
                    failures++;
                    $display("FAIL %s_word: got s=%0d l=%b expected %0d %b",
                             name, dato_s, dato_last, exp_q[0], exp_q.size() == 1);
                end
                void'(exp_q.pop_front());
            end
            prev_stall = dato_valid && !dato_ready;
            prev_s = dato_s; prev_l = dato_last;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d words missing expected 0", name, exp_q.size());
        end
        checks++;
        if (dato_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_end: got valid=%b req_ready=%b expected 0/1", name, dato_valid, req_ready);
        end
    endtask

    // Cycle-exact: 90,80,40,60 on consecutive cycles, last on 60.
    task automatic test_basic();
        logic [7:0] exp [4];
        exp = '{90, 80, 40, 60};
        @(negedge clk);
        req_valid = 1'b1; req_dir = 8'd0; req_len = 4'd3; dato_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dato_valid !== 1'b1 || dato_s !== exp[k] || dato_last !== (k == 3)) begin
                failures++;
                $display("FAIL basic_word%0d: got v=%b s=%0d l=%b expected 1 %0d %b",
                         k, dato_valid, dato_s, dato_last, exp[k], k == 3);
            end
            @(negedge clk);
        end
        checks++;
        if (dato_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end: got v=%b rr=%b busy=%b expected 0 1 0", dato_valid, req_ready, busy);
        end
    endtask

    // Stall for 3 cycles on the first word, then drain.
    task automatic test_stall();
        logic [7:0] exp [3];
        exp = '{40, 60, 50};
        @(negedge clk);
        req_valid = 1'b1; req_dir = 8'd2; req_len = 4'd2; dato_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dato_valid !== 1'b1 || dato_s !== 8'd40 || dato_last !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b s=%0d l=%b expected 1 40 0", k, dato_valid, dato_s, dato_last);
            end
            if (k == 2) dato_ready = 1'b1;
            @(negedge clk);
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (dato_valid !== 1'b1 || dato_s !== exp[k] || dato_last !== (k == 2)) begin
                failures++;
                $display("FAIL stall_word%0d: got v=%b s=%0d l=%b expected 1 %0d %b",
                         k, dato_valid, dato_s, dato_last, exp[k], k == 2);
            end
            @(negedge clk);
        end
        checks++;
        if (dato_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_end: got valid=%b expected 0", dato_valid);
        end
    endtask

    task automatic test_err(input int dir);
        @(negedge clk);
        req_valid = 1'b1; req_dir = 8'(dir); req_len = 4'($urandom_range(15));
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || dato_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse dir=%0d: got err=%b v=%b rr=%b expected 1 0 1", dir, err, dato_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || dato_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_clear dir=%0d: got err=%b v=%b expected 0 0", dir, err, dato_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_dir = 8'd0; req_len = 4'd7; dato_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dato_s !== 8'd80) begin
            failures++;
            $display("FAIL rstmid_word2: got %0d expected 80", dato_s);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dato_valid, dato_s, dato_last, err, busy} !== 12'h0) begin
            failures++;
            $display("FAIL rstmid_async: got v=%b s=%0d l=%b e=%b b=%b expected all 0",
                     dato_valid, dato_s, dato_last, err, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || dato_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_after%0d: got rr=%b v=%b expected 1 0", k, req_ready, dato_valid);
            end
        end
    endtask

    // A request raised during a burst must wait for IDLE, then start normally.
    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_dir = 8'd3; req_len = 4'd1; dato_ready = 1'b1;
        @(negedge clk);
        req_dir = 8'd5; req_len = 4'd0;
        checks++;
        if (dato_s !== 8'd60 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got s=%0d rr=%b expected 60 0", dato_s, req_ready);
        end
        @(negedge clk);
        checks++;
        if (dato_s !== 8'd50 || dato_last !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_last: got s=%0d l=%b rr=%b expected 50 1 0", dato_s, dato_last, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || dato_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got rr=%b v=%b expected 1 0", req_ready, dato_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (dato_valid !== 1'b1 || dato_s !== 8'd40 || dato_last !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got v=%b s=%0d l=%b expected 1 40 1", dato_valid, dato_s, dato_last);
        end
        @(negedge clk);
        checks++;
        if (dato_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end: got v=%b rr=%b expected 0 1", dato_valid, req_ready);
        end
    endtask

    task automatic test_random();
        int dir;
        for (int n = 0; n < 40; n++) begin
            dir = $urandom_range(15);
            if (dir >= TB_DEPTH) test_err(dir);
            else run_burst(dir, $urandom_range(15), $urandom_range(30, 100), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        run_burst(10, 3, 100, "wrap");
        test_stall();
        test_err(12);
        test_err(255);
        test_reset_mid();
        test_back_to_back();
        run_burst(11, 15, 100, "wrap_full");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter DEPTH, default 12: number of ROM words, range 2..256.
REQ-003 Parameter ADDR_W, default 8: address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter LEN_W, default 4: burst length field width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  burst request present.
REQ-009 req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
REQ-010 req_dir  in  ADDR_W  burst start address.
REQ-011 req_len  in  LEN_W  burst length minus one; 0 gives 1 word, max gives 2^LEN_W words.
REQ-012 dato_valid  out  1  dato_s holds a valid word.
REQ-013 dato_ready  in  1  consumer accepts word when dato_valid && dato_ready.
REQ-014 dato_s  out  DATA_W  ROM word.
REQ-015 dato_last  out  1  qualifies final word of burst.
REQ-016 err  out  1  one-cycle pulse: request rejected as out of range.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 ROM contents SHALL be constant, taken from the package table; entries 0..11 = 90,80,40,60,50,40,30,20,10,100,101,102; entries >= 12 = 0.
REQ-019 FSM states: IDLE, READ, DRAIN.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE, accepted request with req_dir < DEPTH -> READ; address counter = req_dir, remaining = req_len.
REQ-022 IDLE, accepted request with req_dir >= DEPTH -> stay IDLE, err = 1 for the next cycle only, no words emitted.
REQ-023 In READ, on every edge where the output register is empty or is consumed that edge, load dato_s = ROM[addr], set dato_valid = 1, advance addr, decrement remaining.
REQ-024 First word SHALL be valid in the cycle after request acceptance (one-cycle latency).
REQ-025 With dato_ready held high, one word per cycle SHALL be delivered, with no bubbles.
REQ-026 Address SHALL wrap from DEPTH-1 to 0 within a burst.
REQ-027 When loading the word with remaining = 0, set dato_last = 1 and go to DRAIN.
REQ-028 DRAIN -> IDLE on the edge where the last word is consumed; req_ready = 1 the following cycle.
REQ-029 While dato_valid && !dato_ready: dato_s, dato_last and dato_valid SHALL hold stable; addr and remaining SHALL not change.
REQ-030 When no word is loaded and the current word is consumed, dato_valid SHALL fall to 0.
REQ-031 req_valid during READ or DRAIN SHALL be ignored; requests are not queued.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, dato_valid 0, dato_s 0, dato_last 0, err 0, busy 0, addr 0, remaining 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst; no residual word appears after release.
REQ-034 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-035 Package rom_pkg SHALL hold the state enum typedef, the ROM content table constant, and the default parameter constants.
REQ-036 Sub-module rom_sync SHALL hold the ROM array with a registered read and a read enable; the FSM and counters stay in rom_burst_reader.

Verification
REQ-037 req_dir=0, req_len=3, dato_ready=1 -> words 90,80,40,60 on 4 consecutive cycles starting 1 cycle after accept; dato_last on 60.
REQ-038 req_dir=10, req_len=3 -> 101,102,90,80 (wrap); dato_last on 80.
REQ-039 req_dir=2, req_len=2; dato_ready low 3 cycles while showing 40 -> 40 held stable; then 40,60,50 delivered in order, none lost or duplicated.
REQ-040 req_dir=12 -> err pulse for 1 cycle, no dato_valid, req_ready stays 1.
REQ-041 rst_n low for 1 cycle during the 2nd word of a req_len=7 burst -> all outputs 0 at once; after release req_ready=1 and no dato_valid.
REQ-042 Last word consumed with a new request waiting -> request accepted the cycle after DRAIN exit; its first word follows 1 cycle later.
